psum_drain: RTL
===============

Name: psum_drain

Overview:
- Downstream consumer of the 5-tap PE chain.
- Captures the chain's final partial sum, adds a bias, and applies round-half-up arithmetic right shift, optional ReLU and saturation to a narrow signed output.
- Buffers results in a small FIFO with a valid/ready output handshake.
- Tracks chain fill latency and frame boundaries, so the chain itself needs no valid signalling.

Parameters:
- DW, 32, width of incoming partial sum and bias.
- OW, 16, width of signed output word.
- LAT, 5, cycles from a sample entering the PE chain to its oPsum being valid (one per PE).
- DEPTH, 8, FIFO entries (power of two).

Ports:
- iCLK  input  1  clock, all logic on rising edge.
- iRST  input  1  synchronous active-high reset.
- iStart  input  1  frame start pulse; IDLE->RUN, flushes block.
- iXValid  input  1  a valid iX is presented to the PE chain this cycle.
- iLast  input  1  qualifies iXValid: this is the frame's final sample.
- iPsum  input  DW  signed oPsum from the PE chain.
- iBias  input  DW  signed bias, sampled with each psum.
- iShift  input  5  right-shift amount 0..31, static within a frame.
- iReluEn  input  1  clamp negatives to 0 when 1.
- oData  output  OW  signed FIFO head.
- oValid  output  1  FIFO non-empty.
- iReady  input  1  consumer accepts oData when oValid&iReady.
- oFull  output  1  FIFO full.
- oOverflow  output  1  sticky: a result was dropped.
- oCount  output  16  results written to FIFO this frame (saturates at 0xFFFF).
- oDone  output  1  one-cycle pulse: frame fully drained into FIFO.

Behaviour:
- Clock, reset and polarity: one clock iCLK; iRST is synchronous, active-high.
- Reset values: all outputs 0, FIFO empty, FSM IDLE, delay line cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: iXValid ignored; iStart -> RUN.
  - RUN: iXValid&iLast -> DRAIN.
  - DRAIN: when delay line and both pipe stages are empty, pulse oDone -> IDLE.
  - iStart in RUN or DRAIN: restart. Delay line, pipe, FIFO, oCount and oOverflow are cleared the same cycle; next state RUN.
- Delay line: LAT-bit shift register of (iXValid & state==RUN), plus a parallel last flag. A 1 at the tail qualifies iPsum that cycle.
- Stage 1 (registered): s1 = sext(iPsum) + sext(iBias), DW+1 bits.
  - If iShift>0, also add 1<<(iShift-1); result is DW+2 bits, no wrap.
- Stage 2 (registered): r = s1 >>> iShift (arithmetic).
  - If iReluEn and r<0, r=0.
  - Saturate to [-2^(OW-1), 2^(OW-1)-1].
- FIFO write: occurs the cycle after stage 2.
- Latency: iXValid in cycle t -> psum captured end of t+LAT -> oValid high in cycle t+LAT+3 (t+8 at defaults), if FIFO was empty.
- FIFO read: pop on oValid&iReady; oData shows the new head the next cycle.
  - Read when empty is a no-op.
- Full:
  - Write with FIFO full and no simultaneous pop: result dropped, oOverflow set (held until iRST/iStart), oCount not incremented.
  - Write with full and pop in the same cycle: accepted, occupancy unchanged.
- Empty: simultaneous write and pop with FIFO empty -> no pop (oValid was 0); the write is stored.
- oDone: asserted in the cycle after the last sample's FIFO write attempt, i.e. t_last+LAT+3. Pulses even if that write was dropped.
- Data in flight: samples after iLast (in DRAIN or IDLE) are ignored. Data already in the delay line keeps flowing to the FIFO.
- iRST mid-frame: everything cleared immediately, including FIFO contents.

Test Plan:
- Latency:
  - Stimulus: iStart, iXValid=1 with iLast=1 at cycle 0; iPsum=0x1000 at cycle 5; iBias=0x100, iShift=4, iReady=0.
  - Response: oValid rises in cycle 8 with oData=0x0110; oCount=1; oDone pulses in cycle 8.
- ReLU and saturation, one per sample, iShift=0:
  - iPsum=-100, iBias=0, iReluEn=1 -> oData=0.
  - iPsum=0x7FFF0000, iBias=0 -> 0x7FFF.
  - iPsum=-0x10000, iBias=0, iReluEn=0 -> 0x8000.
- Rounding: iShift=1 with iPsum=3, then iPsum=-3, iBias=0 -> outputs 2 and -1.
- Overflow:
  - Stimulus: iReady=0, 10 consecutive valid samples.
  - Response: 8 stored, oFull=1, oOverflow=1, oCount=8. Then iReady=1 -> the first 8 results pop in order, oOverflow stays 1.
- Full with simultaneous pop: FIFO full, iReady=1 and a new write in the same cycle -> accepted; oOverflow stays 0; occupancy stays 8.
- Restart: iStart asserted 3 cycles after 4 valid samples (none yet written) -> no output ever appears; oCount=0. A following sample then gives oValid at its t+8.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain: downstream consumer of the 5-tap PE chain.
//
// Takes the chain's final partial sum, adds a bias, applies a round-half-up
// arithmetic right shift, optional ReLU and saturation to a narrow signed
// word, and buffers the results in a small FIFO. The chain carries no valid
// signalling. A delay line matching the chain latency works out which cycles
// carry a real psum.
//
// Ports:
//   iCLK, iRST       clock (rising edge) and synchronous active-high reset
//   iStart           frame start pulse; flushes the block and enters RUN
//   iXValid, iLast   sample presented to the PE chain / final sample of frame
//   iPsum, iBias     signed partial sum from the chain and bias (DW bits)
//   iShift, iReluEn  right-shift amount 0..31, clamp negatives to zero
//   oData, oValid    FIFO head and FIFO non-empty
//   iReady           consumer accepts oData when oValid & iReady
//   oFull            FIFO full
//   oOverflow        sticky: a result was dropped because the FIFO was full
//   oCount           results written this frame (saturating)
//   oDone            one-cycle pulse once the frame has drained into the FIFO
//   oState           FSM state (0 IDLE, 1 RUN, 2 DRAIN) for observation
//
// Handshake: a word leaves the FIFO on every rising edge where oValid and
// iReady are both high. oData is held stable while oValid is high and iReady
// is low. oValid never depends on iReady.
module psum_drain #(
  parameter int DW    = 32,
  parameter int OW    = 16,
  parameter int LAT   = 5,
  parameter int DEPTH = 8
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iStart,
  input  logic          iXValid,
  input  logic          iLast,
  input  logic [DW-1:0] iPsum,
  input  logic [DW-1:0] iBias,
  input  logic [4:0]    iShift,
  input  logic          iReluEn,
  output logic [OW-1:0] oData,
  output logic          oValid,
  input  logic          iReady,
  output logic          oFull,
  output logic          oOverflow,
  output logic [15:0]   oCount,
  output logic          oDone,
  output logic [1:0]    oState
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DW+1:0] RND_ONE = {{(DW+1){1'b0}}, 1'b1};
  localparam logic signed [DW+1:0] SAT_MAX = {{(DW+3-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [DW+1:0] SAT_MIN = {{(DW+3-OW){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  // Delay line: bit 0 is the newest sample, bit LAT-1 lines up with the
  // cycle in which that sample's psum appears at the end of the chain.
  logic [LAT-1:0] dl_v;
  logic [LAT-1:0] dl_last;
  logic           sample_in;

  logic                  s1_v;
  logic signed [DW+1:0]  s1;
  logic signed [DW+1:0]  s1_sum;
  logic signed [DW+1:0]  psum_x, bias_x, rnd;

  logic                  s2_v;
  logic [OW-1:0]         s2;
  logic signed [DW+1:0]  sh;
  logic [OW-1:0]         s2_nx;

  logic                  pipe_empty;

  logic [OW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  fifo_full, pop, push, drop;

  // ---------------------------------------------------------------- FSM
  assign sample_in  = iXValid && (state == RUN);
  assign pipe_empty = ~|dl_v && ~|dl_last && !s1_v && !s2_v;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    oDone    = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) state_nx = RUN;
      end
      RUN: begin
        if (iStart)                 state_nx = RUN;
        else if (iXValid && iLast)  state_nx = DRAIN;
      end
      DRAIN: begin
        if (iStart) begin
          state_nx = RUN;
        end else if (pipe_empty) begin
          oDone    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign oState = state;

  // ---------------------------------------------------------- datapath
  always_comb begin
    psum_x = {{2{iPsum[DW-1]}}, iPsum};
    bias_x = {{2{iBias[DW-1]}}, iBias};
    // Half of one output LSB, so the truncating shift rounds half up.
    rnd    = (iShift != 5'd0) ? (RND_ONE << (iShift - 5'd1)) : '0;
    s1_sum = psum_x + bias_x + rnd;
  end

  always_comb begin
    sh = s1 >>> iShift;
    if (iReluEn && sh[DW+1]) sh = '0;
    if (sh > SAT_MAX)      s2_nx = SAT_MAX[OW-1:0];
    else if (sh < SAT_MIN) s2_nx = SAT_MIN[OW-1:0];
    else                   s2_nx = sh[OW-1:0];
  end

  always_ff @(posedge iCLK) begin
    if (iRST || iStart) begin
      dl_v    <= '0;
      dl_last <= '0;
      s1_v    <= 1'b0;
      s1      <= '0;
      s2_v    <= 1'b0;
      s2      <= '0;
    end else begin
      dl_v    <= {dl_v[LAT-2:0], sample_in};
      dl_last <= {dl_last[LAT-2:0], sample_in && iLast};
      s1_v    <= dl_v[LAT-1];
      s1      <= s1_sum;
      s2_v    <= s1_v;
      s2      <= s2_nx;
    end
  end

  // --------------------------------------------------------------- FIFO
  assign fifo_full = (count == FULL_CNT);
  assign pop       = (count != '0) && iReady;
  // A pop in the same cycle frees a slot, so a write into a full FIFO
  // is still accepted then.
  assign push      = s2_v && (!fifo_full || pop);
  assign drop      = s2_v && fifo_full && !pop;

  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr] <= s2;
  end

  always_ff @(posedge iCLK) begin
    if (iRST || iStart) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      oOverflow <= 1'b0;
      oCount    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) oOverflow <= 1'b1;
      if (push && (oCount != 16'hFFFF)) oCount <= oCount + 16'd1;
    end
  end

  assign oValid = (count != '0);
  assign oFull  = fifo_full;
  // Gate the head so oData is zero, not stale memory, whenever empty.
  assign oData  = oValid ? mem[rd_ptr] : '0;

endmodule
